and_interlock: RTL and testbench
================================

# and_interlock

Parametrised N-channel debounced AND interlock for the flight control unit's discrete inputs, such as gear-down, door-closed and arming switches. Each raw channel is debounced, optionally masked, and AND-reduced. The result drives a registered `y` through a small arming state machine. A compile-time option latches a trip whenever an armed interlock drops.

## Interface
- `N_CH`, default 4: number of input channels, minimum 1.
- `DEBOUNCE`, default 8: consecutive differing samples needed to flip a channel's stable value, minimum 1.
- `CNT_W`, default `$clog2(DEBOUNCE+1)`: width of the per-channel debounce counter.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: interlock enable. Low forces IDLE.
- `ch_in`, in, N_CH: raw discrete inputs, already synchronised upstream.
- `mask`, in, N_CH: 1 excludes the channel from the AND.
- `clear`, in, 1: trip acknowledge, level-sampled.
- `ch_stable`, out, N_CH: debounced channel values.
- `y`, out, 1: registered interlock output.
- `trip`, out, 1: latched trip flag.
- `state`, out, 2: FSM state. IDLE=0, ARMED=1, TRIPPED=2.

## Operation
- **Reset** (`rst_n`=0 at a rising edge): `ch_stable`=0, all counters=0, `state`=IDLE, `y`=0, `trip`=0.
- **Debounce, per channel:**
  - At each edge where `ch_in[i]` != `ch_stable[i]`, the counter increments.
  - When it would reach DEBOUNCE, `ch_stable[i]` toggles and the counter returns to 0.
  - Any edge where `ch_in[i]` == `ch_stable[i]` resets the counter to 0.
  - The counter never exceeds DEBOUNCE-1.
- **Combine:** `y_and` = AND over i of (`ch_stable[i]` | `mask[i]`). If `mask` is all ones, `y_and`=0, so an all-masked interlock never passes.
- **FSM** (priority order: `en` low, then the rules below):
  - IDLE: if `en` && `y_and`, go to ARMED.
  - ARMED: if !`y_and`, go to TRIPPED and set `trip`=1.
  - TRIPPED: if `clear` && `y_and`, go to ARMED and set `trip`=0. If `clear` && !`y_and`, stay TRIPPED.
  - Any state with `en`=0: go to IDLE and set `trip`=0.
- **Output:** `y`=1 only in ARMED. `y` is registered, i.e. the state and `y` update on the same edge.
- `ch_stable` keeps debouncing regardless of `en` or `state`.

## Timing
- `ch_in` step to `ch_stable` flip: DEBOUNCE edges. The flip happens on the DEBOUNCE-th consecutive differing sample.
- `ch_stable`/`mask` change to `y` change: 1 edge. Total `ch_in` to `y` is DEBOUNCE+1 edges.
- A glitch lasting DEBOUNCE-1 cycles or fewer produces no `ch_stable` or `y` change.
- A `mask` change affects `y` on the next edge, with no debounce.
- `clear` takes effect on the edge where it is sampled together with `y_and`=1.
- `rst_n` low mid-debounce discards partial counts; the sequence restarts from 0 after release.
- `en` falling in ARMED or TRIPPED: `y`=0 and `trip`=0 on the next edge.

## Configuration
- `AND_INTERLOCK_TRIP_LATCH_EN` defined:
  - TRIPPED state and the `trip` latch exist as described in Operation.
- `AND_INTERLOCK_TRIP_LATCH_EN` undefined:
  - No TRIPPED state. ARMED with !`y_and` goes to IDLE.
  - IDLE re-arms automatically once `y_and` returns.
  - `trip` is tied to 0 and `clear` is ignored.
  - `state` never reports 2.

## Structure
- Package `and_interlock_pkg`:
  - state typedef `ilk_state_t` and its encodings IDLE/ARMED/TRIPPED.
  - `ILK_STATE_W`=2.
- Sub-module `ch_debounce`:
  - one per channel, generated N_CH times.
  - parameter `DEBOUNCE`.
  - ports `clk`, `rst_n`, `din`, `dout`.
- The top level holds the mask/AND reduction and the FSM.

## Test plan
Parameters `N_CH`=4, `DEBOUNCE`=4, macro defined unless stated.
- **Reset:** hold `rst_n`=0 for 3 edges with `ch_in`=4'hF, `en`=1 → `ch_stable`=0, `y`=0, `trip`=0, `state`=0.
- **Arm:** release reset, `ch_in`=4'hF, `mask`=0, `en`=1 → `ch_stable`=4'hF after edge 4, `y`=1 and `state`=1 after edge 5.
- **Glitch and trip:**
  - From ARMED, drop `ch_in[2]` for 3 cycles → no change.
  - Drop it for 4 cycles → `ch_stable`=4'hB at edge 4, then `y`=0, `trip`=1, `state`=2 at edge 5.
- **Clear:**
  - Pulse `clear` while `ch_stable[2]`=0 → stays TRIPPED.
  - Restore `ch_in[2]`, wait 4 edges, pulse `clear` → `y`=1, `trip`=0, `state`=1.
- **Mask:**
  - `mask`=4'b0100 with `ch_in`=4'hB stable → `y`=1.
  - Set `mask`=4'hF → `y`=0 on the next edge.
- **Macro off:** repeat the trip scenario → `state` returns to 0, `trip` stays 0, and `y`=1 again one edge after `ch_stable[2]` re-stabilises to 1.

Source files
------------

// File: rtl/and_interlock_pkg.sv
// and_interlock_pkg
// Shared definitions for the debounced AND interlock: the arming state
// machine's width and its state encodings.
//
// Build option: AND_INTERLOCK_TRIP_LATCH_EN (see and_interlock.sv) decides
// whether the TRIPPED encoding is ever reached; the encoding is always defined.
package and_interlock_pkg;

    localparam int ILK_STATE_W = 2;

    typedef enum logic [ILK_STATE_W-1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } ilk_state_t;

endpackage

// File: rtl/and_interlock_ch_debounce.sv
// ch_debounce
// Single-channel debouncer. The stable output flips only after DEBOUNCE
// consecutive samples that disagree with it; any agreeing sample restarts
// the count. A glitch shorter than DEBOUNCE samples is therefore invisible.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (clears count and output)
//   din   - raw, already-synchronised discrete input
//   dout  - debounced value (registered)
module ch_debounce #(
    parameter int DEBOUNCE = 8,
    parameter int CNT_W    = $clog2(DEBOUNCE + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    // Count value on which the next disagreeing sample flips the output,
    // so the counter itself never holds DEBOUNCE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;

    // Next-state: count disagreeing samples, flip on the DEBOUNCE-th one.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (din != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = ~dout_q;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= {CNT_W{1'b0}};
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/and_interlock.sv
// and_interlock
// N-channel debounced AND interlock. Each raw channel is debounced by its own
// ch_debounce instance, masked channels are forced true, and the AND of the
// result feeds a small arming FSM whose outputs are registered.
//
// Build option AND_INTERLOCK_TRIP_LATCH_EN:
//   defined   - an armed interlock that drops goes to TRIPPED and latches
//               trip until clear is sampled with the AND true again.
//   undefined - no TRIPPED state; a drop returns to IDLE and re-arms on its
//               own; trip is always 0 and clear is ignored.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   en        - interlock enable, low forces IDLE
//   ch_in     - raw discrete inputs [N_CH]
//   mask      - 1 excludes the channel from the AND [N_CH]
//   clear     - trip acknowledge, level-sampled
//   ch_stable - debounced channel values [N_CH]
//   y         - registered interlock output, 1 only in ARMED
//   trip      - latched trip flag
//   state     - FSM state (IDLE=0, ARMED=1, TRIPPED=2)
module and_interlock
    import and_interlock_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DEBOUNCE = 8,
    parameter int CNT_W    = $clog2(DEBOUNCE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_CH-1:0]        ch_in,
    input  logic [N_CH-1:0]        mask,
    input  logic                   clear,
    output logic [N_CH-1:0]        ch_stable,
    output logic                   y,
    output logic                   trip,
    output logic [ILK_STATE_W-1:0] state
);

    logic [N_CH-1:0] ch_stable_s;
    logic [N_CH-1:0] pass_s;
    logic            y_and_s;

    ilk_state_t state_q;
    ilk_state_t state_d;
    logic       y_q;
    logic       y_d;
    logic       trip_q;
    logic       trip_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ch_debounce #(
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (ch_in[i]),
            .dout  (ch_stable_s[i])
        );
    end

    // A fully masked interlock must never pass, hence the extra term.
    assign pass_s  = ch_stable_s | mask;
    assign y_and_s = (&pass_s) & ~(&mask);

`ifndef AND_INTERLOCK_TRIP_LATCH_EN
    // Without the trip latch the acknowledge has no function.
    logic unused_clear_s;
    assign unused_clear_s = clear;
`endif

    // FSM state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= 1'b0;
            trip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            trip_q  <= trip_d;
        end
    end

    // FSM next state; enable low overrides every other rule.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (y_and_s) begin
                        state_d = ARMED;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARMED: begin
                    if (!y_and_s) begin
`ifdef AND_INTERLOCK_TRIP_LATCH_EN
                        state_d = TRIPPED;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = ARMED;
                    end
                end
`ifdef AND_INTERLOCK_TRIP_LATCH_EN
                TRIPPED: begin
                    // Acknowledge only counts once the interlock is whole again.
                    if (clear && y_and_s) begin
                        state_d = ARMED;
                    end else begin
                        state_d = TRIPPED;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM outputs, decoded from the next state so they register alongside it.
    always_comb begin
        y_d    = (state_d == ARMED) ? 1'b1 : 1'b0;
`ifdef AND_INTERLOCK_TRIP_LATCH_EN
        trip_d = (state_d == TRIPPED) ? 1'b1 : 1'b0;
`else
        trip_d = 1'b0;
`endif
    end

    assign ch_stable = ch_stable_s;
    assign y         = y_q;
    assign trip      = trip_q;
    assign state     = state_q;

endmodule

// File: tb/tb_and_interlock.sv
// Testbench for and_interlock (N_CH=4, DEBOUNCE=4). A directed table walks
// the reset / arm / glitch / trip / clear / mask / enable sequence, then a
// randomized run is compared against a behavioural model every cycle.
// Expectations adapt to whether AND_INTERLOCK_TRIP_LATCH_EN is defined.
module tb_and_interlock;

    localparam int N_CH = 4;
    localparam int DEB  = 4;

`ifdef AND_INTERLOCK_TRIP_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] ch_in;
    logic [3:0] mask;
    logic       clear;
    logic [3:0] ch_stable;
    logic       y;
    logic       trip;
    logic [1:0] state;

    always #5 clk = ~clk;

    and_interlock #(
        .N_CH     (N_CH),
        .DEBOUNCE (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ch_in     (ch_in),
        .mask      (mask),
        .clear     (clear),
        .ch_stable (ch_stable),
        .y         (y),
        .trip      (trip),
        .state     (state)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-channel run length of disagreeing samples,
    // plus the interlock state as a plain integer (0 idle, 1 armed, 2 tripped).
    bit [3:0] m_stable;
    int       m_run [4];
    int       m_state;

    typedef struct {
        bit       rst_n;
        bit       en;
        bit [3:0] ch_in;
        bit [3:0] mask;
        bit       clear;
        bit [3:0] exp_stable;
        bit       exp_y;
        bit       exp_trip;
        int       exp_state;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Row helper: y1/t1/s1 apply with the trip latch, y0/s0 without it.
    task automatic add(input bit r, input bit e, input bit [3:0] c, input bit [3:0] m,
                       input bit cl, input bit [3:0] st,
                       input bit y1, input bit t1, input int s1,
                       input bit y0, input int s0);
        vec_t v;
        v.rst_n = r; v.en = e; v.ch_in = c; v.mask = m; v.clear = cl;
        v.exp_stable = st;
        v.exp_y      = LATCH ? y1 : y0;
        v.exp_trip   = LATCH ? t1 : 1'b0;
        v.exp_state  = LATCH ? s1 : s0;
        vecs.push_back(v);
    endtask

    task automatic model_edge();
        bit ya;
        ya = ((m_stable | mask) == 4'hF) && (mask != 4'hF);
        if (!rst_n) begin
            m_stable = 4'h0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_state = 0;
        end else begin
            if (!en) m_state = 0;
            else if (m_state == 0) begin
                if (ya) m_state = 1;
            end else if (m_state == 1) begin
                if (!ya) m_state = LATCH ? 2 : 0;
            end else if (m_state == 2) begin
                if (clear && ya) m_state = 1;
            end
            for (int i = 0; i < 4; i++) begin
                if (ch_in[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = ~m_stable[i];
                        m_run[i]    = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    // One clock: update the model at the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model.ch_stable", 32'(ch_stable), 32'(m_stable));
        chk("model.y",         32'(y),         32'(m_state == 1));
        chk("model.trip",      32'(trip),      32'(m_state == 2));
        chk("model.state",     32'(state),     32'(m_state));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; ch_in = 4'hF; mask = 4'h0; clear = 1'b0;
        m_stable = 4'h0; m_state = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;

        // Reset with inputs active
        for (int k = 0; k < 3; k++) add(0, 1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        // Arm: stable after edge 4, y after edge 5
        for (int k = 0; k < 3; k++) add(1, 1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 4'hF, 1, 0, 1, 1, 1);
        // 3-cycle glitch on ch2: no effect
        for (int k = 0; k < 3; k++) add(1, 1, 4'hB, 4'h0, 0, 4'hF, 1, 0, 1, 1, 1);
        add(1, 1, 4'hF, 4'h0, 0, 4'hF, 1, 0, 1, 1, 1);
        // 4-cycle drop: stable flips at edge 4, trip at edge 5
        for (int k = 0; k < 3; k++) add(1, 1, 4'hB, 4'h0, 0, 4'hF, 1, 0, 1, 1, 1);
        add(1, 1, 4'hB, 4'h0, 0, 4'hB, 1, 0, 1, 1, 1);
        add(1, 1, 4'hB, 4'h0, 0, 4'hB, 0, 1, 2, 0, 0);
        // Clear while ch2 still low: stays tripped
        add(1, 1, 4'hB, 4'h0, 1, 4'hB, 0, 1, 2, 0, 0);
        // Restore ch2
        for (int k = 0; k < 3; k++) add(1, 1, 4'hF, 4'h0, 0, 4'hB, 0, 1, 2, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 4'hF, 0, 1, 2, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 4'hF, 0, 1, 2, 1, 1);
        add(1, 1, 4'hF, 4'h0, 1, 4'hF, 1, 0, 1, 1, 1);
        // Mask ch2 while it drops: stays armed
        for (int k = 0; k < 3; k++) add(1, 1, 4'hB, 4'h4, 0, 4'hF, 1, 0, 1, 1, 1);
        add(1, 1, 4'hB, 4'h4, 0, 4'hB, 1, 0, 1, 1, 1);
        add(1, 1, 4'hB, 4'h4, 0, 4'hB, 1, 0, 1, 1, 1);
        // All masked: drops next edge
        add(1, 1, 4'hB, 4'hF, 0, 4'hB, 0, 1, 2, 0, 0);
        // Enable low from tripped/idle, then re-arm
        add(1, 0, 4'hB, 4'hF, 0, 4'hB, 0, 0, 0, 0, 0);
        add(1, 0, 4'hB, 4'h4, 0, 4'hB, 0, 0, 0, 0, 0);
        add(1, 1, 4'hB, 4'h4, 0, 4'hB, 1, 0, 1, 1, 1);
        // Reset mid-debounce discards partial counts
        add(1, 1, 4'hF, 4'h0, 0, 4'hB, 0, 1, 2, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 4'hB, 0, 1, 2, 0, 0);
        add(0, 1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 4'hF, 0, 0, 0, 0, 0);
        add(1, 1, 4'hF, 4'h0, 0, 4'hF, 1, 0, 1, 1, 1);

        foreach (vecs[k]) begin
            rst_n = vecs[k].rst_n; en = vecs[k].en; ch_in = vecs[k].ch_in;
            mask = vecs[k].mask; clear = vecs[k].clear;
            tick();
            chk($sformatf("vec%0d.ch_stable", k), 32'(ch_stable), 32'(vecs[k].exp_stable));
            chk($sformatf("vec%0d.y", k),         32'(y),         32'(vecs[k].exp_y));
            chk($sformatf("vec%0d.trip", k),      32'(trip),      32'(vecs[k].exp_trip));
            chk($sformatf("vec%0d.state", k),     32'(state),     32'(vecs[k].exp_state));
        end

        // Randomized run: channels mostly hold, occasional glitches and steps.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) ch_in[i] = ~ch_in[i];
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 9) == 0) mask = 4'h0;
            en    = ($urandom_range(0, 39) != 0);
            clear = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
